// File: rtl/pong_pkg.sv
// Shared types, codes and helpers for the Pong round sequencer.
package pong_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
  endfunction

  function automatic logic [1:0] win_code(input logic [SCORE_W-1:0] s1,
                                          input logic [SCORE_W-1:0] s2);
    if (s1 > s2)      return WIN_P1;
    else if (s2 > s1) return WIN_P2;
    else              return WIN_DRAW;
  endfunction

endpackage

// File: rtl/pong_sec_timer.sv
// Frame prescaler plus two-digit BCD countdown of remaining game seconds.
module pong_sec_timer
  import pong_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned GAME_SEC_TENS  = 9,
  parameter int unsigned GAME_SEC_ONES  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             frame_tick,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             expired
);

  localparam int unsigned PW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  logic [PW-1:0] presc;
  logic          wrap;
  logic          zero;

  assign zero = (sec_tens == '0) && (sec_ones == '0);
  assign wrap = en && frame_tick && (presc == PW'(FRAMES_PER_SEC - 1));

  // Flags the cycle in which the count reaches (or already sits at) 00
  assign expired = en && (zero || (wrap && (sec_tens == '0) && (sec_ones == BCD_W'(1))));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      presc    <= '0;
      sec_tens <= BCD_W'(GAME_SEC_TENS);
      sec_ones <= BCD_W'(GAME_SEC_ONES);
    end else if (en && frame_tick) begin
      if (wrap) begin
        presc <= '0;
        if (!zero) begin
          if (sec_ones == '0) begin
            sec_ones <= BCD_W'(9);
            sec_tens <= sec_tens - BCD_W'(1);
          end else begin
            sec_ones <= sec_ones - BCD_W'(1);
          end
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Round sequencer for the Pong datapath: serve delay, timer, scoring, win/draw.
// Optional PONG_CTRL_PAUSE_EN: pause level freezes play without re-centring.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned SERVE_FRAMES   = 90,
  parameter int unsigned WIN_SCORE      = 7,
  parameter int unsigned GAME_SEC_TENS  = 9,
  parameter int unsigned GAME_SEC_ONES  = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               frame_tick,
  input  logic               miss1,
  input  logic               miss2,
  output logic               stop,
  output logic               move_en,
  output logic [BCD_W-1:0]   sec_tens,
  output logic [BCD_W-1:0]   sec_ones,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned SW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES + 1) : 1;

  state_t             state;
  state_t             nxt_state;
  logic [SW-1:0]      serve_cnt;
  logic [SCORE_W-1:0] nxt_s1;
  logic [SCORE_W-1:0] nxt_s2;
  logic               load;
  logic               hold;
  logic               run;
  logic               serve_done;
  logic               expired;

`ifdef PONG_CTRL_PAUSE_EN
  assign hold = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign hold = 1'b0;
`endif

  assign run        = (state == ST_PLAY) && !hold;
  assign move_en    = run && frame_tick;
  assign serve_done = frame_tick && (serve_cnt == SW'(SERVE_FRAMES - 1));
  assign state_o    = state;

  pong_sec_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC),
    .GAME_SEC_TENS (GAME_SEC_TENS),
    .GAME_SEC_ONES (GAME_SEC_ONES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .en        (run),
    .frame_tick(frame_tick),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .expired   (expired)
  );

  // Next state and next scores; time-out outranks a point
  always_comb begin
    nxt_state = state;
    nxt_s1    = score1;
    nxt_s2    = score2;
    load      = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          nxt_state = ST_SERVE;
          nxt_s1    = '0;
          nxt_s2    = '0;
          load      = 1'b1;
        end
      end
      ST_SERVE: if (serve_done) nxt_state = ST_PLAY;
      ST_PLAY: begin
        if (run) begin
          if (miss1 && !miss2) nxt_s2 = sat_inc(score2);
          if (miss2 && !miss1) nxt_s1 = sat_inc(score1);
          if (miss1 || miss2)  nxt_state = ST_POINT;
          if (expired)         nxt_state = ST_OVER;
        end
      end
      ST_POINT: begin
        if ((score1 >= SCORE_W'(WIN_SCORE)) || (score2 >= SCORE_W'(WIN_SCORE)))
          nxt_state = ST_OVER;
        else
          nxt_state = ST_SERVE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      stop      <= 1'b1;
      score1    <= '0;
      score2    <= '0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
      serve_cnt <= '0;
    end else begin
      state     <= nxt_state;
      stop      <= (nxt_state != ST_PLAY);
      score1    <= nxt_s1;
      score2    <= nxt_s2;
      game_over <= (nxt_state == ST_OVER);
      if (load)
        winner <= WIN_NONE;
      else if ((nxt_state == ST_OVER) && (state != ST_OVER))
        winner <= win_code(nxt_s1, nxt_s2);
      if (load || (state != ST_SERVE) || serve_done)
        serve_cnt <= '0;
      else if (frame_tick)
        serve_cnt <= serve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: default build plus a short-game instance.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, pause, frame_tick, miss1, miss2;
  logic       stop, move_en, game_over;
  logic [3:0] sec_tens, sec_ones, score1, score2;
  logic [1:0] winner;
  logic [2:0] state_o;

  logic       b_start, b_tick, b_miss1;
  logic       b_stop, b_move_en, b_game_over;
  logic [3:0] b_tens, b_ones, b_score1, b_score2;
  logic [1:0] b_winner;
  logic [2:0] b_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .frame_tick(frame_tick),
    .miss1(miss1), .miss2(miss2), .stop(stop), .move_en(move_en),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .score1(score1), .score2(score2),
    .game_over(game_over), .winner(winner), .state_o(state_o)
  );

  pong_game_ctrl #(
    .FRAMES_PER_SEC(2), .SERVE_FRAMES(2), .WIN_SCORE(7),
    .GAME_SEC_TENS(0), .GAME_SEC_ONES(1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .pause(1'b0), .frame_tick(b_tick),
    .miss1(b_miss1), .miss2(1'b0), .stop(b_stop), .move_en(b_move_en),
    .sec_tens(b_tens), .sec_ones(b_ones), .score1(b_score1), .score2(b_score2),
    .game_over(b_game_over), .winner(b_winner), .state_o(b_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic play_point(input logic m1, input logic m2);
    tick(90);
    miss1 = m1;
    miss2 = m2;
    step();
    miss1 = 1'b0;
    miss2 = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; frame_tick = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
    b_start = 1'b0; b_tick = 1'b0; b_miss1 = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_stop", 32'(stop), 1);
    chk("rst_move_en", 32'(move_en), 0);
    chk("rst_score1", 32'(score1), 0);
    chk("rst_score2", 32'(score2), 0);
    chk("rst_tens", 32'(sec_tens), 9);
    chk("rst_ones", 32'(sec_ones), 9);
    chk("rst_game_over", 32'(game_over), 0);
    chk("rst_winner", 32'(winner), 0);

    // start, then serve delay of exactly 90 frame ticks
    start = 1'b1; step(); start = 1'b0;
    chk("start_state", 32'(state_o), 1);
    tick(89);
    chk("serve89_state", 32'(state_o), 1);
    chk("serve89_stop", 32'(stop), 1);
    tick(1);
    chk("serve90_state", 32'(state_o), 2);
    chk("serve90_stop", 32'(stop), 0);

    // one game second, then ten seconds
    tick(59);
    chk("t59_ones", 32'(sec_ones), 9);
    frame_tick = 1'b1; #1;
    chk("move_en_hi", 32'(move_en), 1);
    step();
    frame_tick = 1'b0; #1;
    chk("move_en_lo", 32'(move_en), 0);
    chk("t60_tens", 32'(sec_tens), 9);
    chk("t60_ones", 32'(sec_ones), 8);
    tick(540);
    chk("t600_tens", 32'(sec_tens), 8);
    chk("t600_ones", 32'(sec_ones), 9);

    // miss2 held for five cycles scores once
    miss2 = 1'b1;
    step();
    chk("miss_point_state", 32'(state_o), 3);
    chk("miss_score1", 32'(score1), 1);
    step();
    chk("point_to_serve", 32'(state_o), 1);
    chk("point_stop", 32'(stop), 1);
    step(); step(); step();
    miss2 = 1'b0;
    chk("miss_hold_score1", 32'(score1), 1);

    // P1 reaches seven
    for (int i = 0; i < 5; i++) play_point(1'b0, 1'b1);
    chk("p1_six", 32'(score1), 6);
    tick(90);
    miss2 = 1'b1; step(); miss2 = 1'b0;
    chk("seventh_state", 32'(state_o), 3);
    chk("seventh_score1", 32'(score1), 7);
    step();
    chk("over_state", 32'(state_o), 4);
    chk("over_game_over", 32'(game_over), 1);
    chk("over_winner", 32'(winner), 1);
    tick(3);
    chk("over_tick_state", 32'(state_o), 4);
    chk("over_frozen_tens", 32'(sec_tens), 8);
    start = 1'b1; step(); start = 1'b0;
    chk("restart_state", 32'(state_o), 1);
    chk("restart_score1", 32'(score1), 0);
    chk("restart_score2", 32'(score2), 0);
    chk("restart_tens", 32'(sec_tens), 9);
    chk("restart_ones", 32'(sec_ones), 9);
    chk("restart_game_over", 32'(game_over), 0);
    chk("restart_winner", 32'(winner), 0);

    // simultaneous misses: point without score
    tick(90);
    miss1 = 1'b1; miss2 = 1'b1; step(); miss1 = 1'b0; miss2 = 1'b0;
    chk("both_state", 32'(state_o), 3);
    chk("both_score1", 32'(score1), 0);
    chk("both_score2", 32'(score2), 0);
    step();
    chk("both_serve", 32'(state_o), 1);

    // reset mid-PLAY at 3/2
    for (int i = 0; i < 3; i++) play_point(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) play_point(1'b1, 1'b0);
    tick(90);
    tick(70);
    chk("pre_rst_state", 32'(state_o), 2);
    chk("pre_rst_score1", 32'(score1), 3);
    chk("pre_rst_score2", 32'(score2), 2);
    chk("pre_rst_ones", 32'(sec_ones), 8);
    rst = 1'b1; start = 1'b1; step(); rst = 1'b0; start = 1'b0;
    chk("mid_rst_state", 32'(state_o), 0);
    chk("mid_rst_score1", 32'(score1), 0);
    chk("mid_rst_score2", 32'(score2), 0);
    chk("mid_rst_tens", 32'(sec_tens), 9);
    chk("mid_rst_ones", 32'(sec_ones), 9);
    chk("mid_rst_stop", 32'(stop), 1);

    // pause behaviour
    start = 1'b1; step(); start = 1'b0;
    tick(90);
    pause = 1'b1;
`ifdef PONG_CTRL_PAUSE_EN
    for (int i = 0; i < 100; i++) begin
      frame_tick = 1'b1; #1;
      chk("pause_move_en", 32'(move_en), 0);
      step();
      frame_tick = 1'b0;
      step();
    end
    chk("pause_ones", 32'(sec_ones), 9);
    chk("pause_stop", 32'(stop), 0);
    chk("pause_state", 32'(state_o), 2);
    pause = 1'b0;
    tick(60);
    chk("resume_ones", 32'(sec_ones), 8);
`else
    frame_tick = 1'b1; #1;
    chk("nopause_move_en", 32'(move_en), 1);
    step();
    frame_tick = 1'b0;
    step();
    tick(59);
    chk("nopause_ones", 32'(sec_ones), 8);
    pause = 1'b0;
`endif

    // short game: miss1 on the expiry cycle
    chk("b_rst_ones", 32'(b_ones), 1);
    b_start = 1'b1; step(); b_start = 1'b0;
    chk("b_serve", 32'(b_state), 1);
    for (int i = 0; i < 2; i++) begin
      b_tick = 1'b1; step(); b_tick = 1'b0; step();
    end
    chk("b_play", 32'(b_state), 2);
    b_tick = 1'b1; step(); b_tick = 1'b0; step();
    chk("b_presc_ones", 32'(b_ones), 1);
    b_tick = 1'b1; b_miss1 = 1'b1; step(); b_tick = 1'b0; b_miss1 = 1'b0;
    chk("b_over_state", 32'(b_state), 4);
    chk("b_score2", 32'(b_score2), 1);
    chk("b_winner", 32'(b_winner), 2);
    chk("b_game_over", 32'(b_game_over), 1);
    chk("b_ones", 32'(b_ones), 0);
    chk("b_tens", 32'(b_tens), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Top-level round sequencer for the Pong datapath (ball/paddle state machine).
- Owns game start, serve delay, per-frame motion enable, BCD countdown clock, score counters, win/draw detection.
- Drives the datapath's stop and sec1 inputs and consumes its miss1/miss2 outputs.
- Sits between the button/VGA timing logic and the ball/paddle datapath.

Parameters:
- FRAMES_PER_SEC, 60, frame_tick pulses per game second
- SERVE_FRAMES, 90, frame ticks the ball is held at centre before each serve
- WIN_SCORE, 7, points that end the game immediately (1..15)
- GAME_SEC_TENS, 9, BCD tens digit of game length
- GAME_SEC_ONES, 9, BCD ones digit of game length

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse from debounced button; begins a new game
- pause  in  1  level; honoured only when PAUSE_EN is defined
- frame_tick  in  1  single-cycle pulse once per video frame
- miss1  in  1  from datapath; ball passed player 1's side
- miss2  in  1  from datapath; ball passed player 2's side
- stop  out  1  to datapath; holds ball and paddles at centre
- move_en  out  1  qualifies the datapath clock enable; equals frame_tick while in PLAY
- sec_tens  out  4  BCD tens digit of remaining time; feeds datapath sec1
- sec_ones  out  4  BCD ones digit of remaining time
- score1  out  4  player 1 points
- score2  out  4  player 2 points
- game_over  out  1  high in OVER
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw; valid when game_over=1
- state_o  out  3  current state, for debug and display

Behaviour:
- Reset (sync, rst=1 at posedge clk):
  - state=IDLE, stop=1, move_en=0.
  - score1=score2=0, sec_tens/sec_ones=GAME_SEC_TENS/ONES.
  - game_over=0, winner=00, all internal counters 0.
  - rst has priority over every other input in the same cycle.
- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4. stop=1 in every state except PLAY.
- IDLE:
  - start → SERVE.
  - Same edge: scores cleared, timer reloaded, serve counter cleared.
- SERVE:
  - Serve counter increments on frame_tick.
  - On the tick that brings the count to SERVE_FRAMES: counter clears, → PLAY.
- PLAY:
  - stop=0, move_en=frame_tick (combinational AND with state==PLAY).
  - Prescaler counts frame ticks 0..FRAMES_PER_SEC-1.
  - On wrap, BCD timer decrements: ones 0 → 9 with tens-1; otherwise ones-1.
  - Timer never wraps below 00.
- Miss handling in PLAY (sampled every clk, not only on frame_tick):
  - miss1 only → score2+1, → POINT.
  - miss2 only → score1+1, → POINT.
  - Both miss1 and miss2 → no score change, → POINT.
  - Scores saturate at 15.
- Time-out: when the timer becomes 00, next state is OVER.
  - If a miss occurs in the same cycle, the score is still applied.
  - OVER takes precedence over POINT.
- POINT (one cycle):
  - Either score ≥ WIN_SCORE → OVER, else → SERVE.
  - Prescaler is retained, so the partial second carries over.
- OVER:
  - game_over=1.
  - winner = 01 if score1>score2, 10 if score2>score1, 11 if equal; registered on entry.
  - Timer and scores frozen.
  - start → SERVE with a fresh game (same clearing as from IDLE).
- start outside IDLE/OVER is ignored.
- frame_tick outside SERVE/PLAY is ignored.

Optional Feature:
- Macro: PONG_CTRL_PAUSE_EN.
- Defined: pause=1 in PLAY forces move_en=0 and freezes the prescaler, timer and miss sampling. stop stays 0, so positions are held, not re-centred. Releasing pause resumes at the exact count.
- Not defined: pause is ignored entirely; port remains for pin compatibility.

Decomposition:
- Shared package pong_pkg:
  - state encoding constants (ST_IDLE..ST_OVER)
  - winner codes (WIN_NONE/P1/P2/DRAW)
  - BCD digit width (4).
- One sub-module, pong_sec_timer, holds the frame prescaler and two-digit BCD down-counter.
  - Inputs: clk, rst, load, en, frame_tick.
  - Outputs: sec_tens, sec_ones, expired.
- FSM, scoring and winner logic remain in pong_game_ctrl.

Test Plan:
- Reset then start pulse → state IDLE→SERVE, scores 0/0, time 9/9; after exactly 90 frame_ticks, state=PLAY and stop=0.
- In PLAY, 60 frame_ticks → time 9/8; 600 ticks from 9/9 → 8/9; move_en pulses coincide with frame_tick only.
- miss2 held 5 cycles in PLAY → score1=1 exactly once, one cycle of POINT, then SERVE with stop=1.
- Run P1 to 7 points → after 7th miss2, POINT→OVER, game_over=1, winner=01; further start → SERVE, scores 0/0.
- Parameters GAME_SEC_TENS=0, GAME_SEC_ONES=1, FRAMES_PER_SEC=2, miss1 on the expiry cycle → score2=1, state OVER, winner=10.
- Assert rst mid-PLAY with scores 3/2 → next edge IDLE, scores 0/0, time 9/9, stop=1; with PONG_CTRL_PAUSE_EN, pause for 100 ticks → time and move_en frozen.
